// File: rtl/imem_loader_pkg.sv
// loader_pkg: shared state encoding and stream-format constants for the imem loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
    localparam int LEN_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] CSUM_INIT = 8'h00;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link plus imem write port; master is the loader side.
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (input byte_valid, byte_data, output byte_ready, imem_we, imem_addr, imem_wdata);
    modport slave (output byte_valid, byte_data, input byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs big-endian bytes into 32-bit words; word_valid marks the 4th byte.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] sh;
    assign word_valid = in_valid && cnt == 2'(BYTES_PER_WORD - 1);
    assign word = {sh, in_data};
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
            sh  <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            sh  <= {sh[15:0], in_data};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length/data/checksum byte stream into imem writes and
// releases cpu_hold only once the whole image has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    localparam int MAX_WORDS = 2 ** ADDR_W;
    state_t        state, nxt;
    logic [15:0]   len, n;
    logic [ADDR_W:0] idx;
    logic [7:0]    csum;
    logic          take, restart, word_valid, last;
    logic [31:0]   word;
    assign take    = bus.byte_valid && bus.byte_ready;
    assign restart = start && (state == IDLE || state == DONE || state == ERR);
    assign n       = {len[15:8], bus.byte_data};
    assign last    = 16'(idx) + 16'd1 == len;
    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .in_valid   (take && state == DATA),
        .in_data    (bus.byte_data),
        .word_valid (word_valid),
        .word       (word)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? HDR_HI : state;
            HDR_HI:          nxt = take ? HDR_LO : state;
            HDR_LO:          nxt = !take ? state : (n == 16'd0 || 32'(n) > MAX_WORDS) ? ERR : DATA;
            DATA:            nxt = (word_valid && last) ? CSUM : state;
            CSUM:            nxt = !take ? state : (bus.byte_data == csum) ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            len            <= '0;
            idx            <= '0;
            csum           <= CSUM_INIT;
        end else begin
            state          <= nxt;
            bus.byte_ready <= nxt inside {HDR_HI, HDR_LO, DATA, CSUM};
            done           <= nxt == DONE;
            error          <= nxt == ERR;
            cpu_hold       <= nxt != DONE;
            bus.imem_we    <= word_valid;
            if (word_valid) begin
                bus.imem_addr  <= idx[ADDR_W-1:0];
                bus.imem_wdata <= word;
                idx            <= idx + 1'b1;
            end
            if (restart) begin
                idx  <= '0;
                csum <= CSUM_INIT;
            end else if (take && state != CSUM) begin
                csum <= csum ^ bus.byte_data;
            end
            if (take && state == HDR_HI) len[15:8] <= bus.byte_data;
            if (take && state == HDR_LO) len[7:0] <= bus.byte_data;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;
    int total = 0;
    int bad = 0;
    int wcount = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] mem [256];
    logic [7:0]  cs;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) begin
            mem[bus.imem_addr] = bus.imem_wdata;
            last_addr = bus.imem_addr;
            wcount++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk);
            ok = bus.byte_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL accept observed=not_accepted expected=accepted byte=%0h", b);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(cpu_hold), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ready", 32'(bus.byte_ready), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_addr", 32'(bus.imem_addr), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.byte_ready), 0);

        // Good two-word image; XOR of the ten preceding bytes is 0x57.
        pulse_start();
        chk("hdr_ready", 32'(bus.byte_ready), 1);
        send(8'h00, 0); send(8'h02, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h01, 0); send(8'h09, 0); send(8'h50, 0); send(8'h20, 0);
        chk("t1_hold_pre", 32'(cpu_hold), 1);
        send(8'h57, 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_hold", 32'(cpu_hold), 0);
        chk("t1_ready", 32'(bus.byte_ready), 0);
        chk("t1_w0", mem[0], 32'h20080005);
        chk("t1_w1", mem[1], 32'h01095020);
        chk("t1_wcount", 32'(wcount), 2);

        // Restart from DONE, then a bad checksum.
        wcount = 0;
        mem[0] = '0;
        mem[1] = '0;
        pulse_start();
        chk("t2_done_clr", 32'(done), 0);
        chk("t2_hold_set", 32'(cpu_hold), 1);
        send(8'h00, 0); send(8'h02, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'h01, 0); send(8'h09, 0); send(8'h50, 0); send(8'h20, 0);
        send(8'h54, 0);
        chk("t2_error", 32'(error), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_hold", 32'(cpu_hold), 1);
        chk("t2_ready", 32'(bus.byte_ready), 0);
        chk("t2_wcount", 32'(wcount), 2);
        chk("t2_w1", mem[1], 32'h01095020);

        // Zero length.
        wcount = 0;
        pulse_start();
        chk("t3_err_clr", 32'(error), 0);
        send(8'h00, 0); send(8'h00, 0);
        chk("t3_zero_err", 32'(error), 1);
        chk("t3_zero_ready", 32'(bus.byte_ready), 0);
        // Oversize length 0x0101.
        pulse_start();
        send(8'h01, 0); send(8'h01, 0);
        repeat (3) @(negedge clk);
        chk("t3_big_err", 32'(error), 1);
        chk("t3_wcount", 32'(wcount), 0);

        // Gapped one-word image with an ignored start mid-DATA; checksum 0x23.
        pulse_start();
        send(8'h00, $urandom_range(0, 3)); send(8'h01, $urandom_range(0, 3));
        send(8'hde, $urandom_range(0, 3)); send(8'had, $urandom_range(0, 3));
        pulse_start();
        send(8'hbe, $urandom_range(0, 3)); send(8'hef, $urandom_range(0, 3));
        send(8'h23, $urandom_range(0, 3));
        chk("t4_w0", mem[0], 32'hdeadbeef);
        chk("t4_wcount", 32'(wcount), 1);
        chk("t4_done", 32'(done), 1);
        chk("t4_hold", 32'(cpu_hold), 0);

        // Reset after five data bytes of a two-word load.
        wcount = 0;
        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_wcount", 32'(wcount), 1);
        chk("t5_w0", mem[0], 32'h11223344);
        chk("t5_hold", 32'(cpu_hold), 1);
        chk("t5_done", 32'(done), 0);
        chk("t5_ready", 32'(bus.byte_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send(8'h00, 0); send(8'h01, 0);
        send(8'h0a, 0); send(8'h0b, 0); send(8'h0c, 0); send(8'h0d, 0);
        send(8'h01, 0);
        chk("t5_fresh_w0", mem[0], 32'h0a0b0c0d);
        chk("t5_fresh_done", 32'(done), 1);

        // Full capacity: 256 words of incrementing bytes.
        wcount = 0;
        pulse_start();
        chk("t6_done_clr", 32'(done), 0);
        chk("t6_hold_set", 32'(cpu_hold), 1);
        cs = 8'h01 ^ 8'h00;
        send(8'h01, 0); send(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            send(8'(i), 0);
            cs = cs ^ 8'(i);
        end
        send(cs, 0);
        chk("t6_wcount", 32'(wcount), 256);
        chk("t6_last_addr", 32'(last_addr), 32'hff);
        chk("t6_w0", mem[0], 32'h00010203);
        chk("t6_w255", mem[255], 32'hfcfdfeff);
        chk("t6_done", 32'(done), 1);
        chk("t6_error", 32'(error), 0);
        pulse_start();
        chk("t6_restart_done", 32'(done), 0);
        chk("t6_restart_hold", 32'(cpu_hold), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
